card_mem_allocator: RTL and testbench
=====================================

// Module: card_mem_allocator
// PURPOSE
//  Card storage for the card-list engine: a 1024x32 single-port synchronous RAM
//  (sub-module ram1024x32) plus a free-slot allocator (allocate_memory function).
//  Each word is one linked-list node: [31]=used, [21:20]=suit, [19:16]=value,
//  [9:0]=next-node address. All other bits are zero.
//  Address 0 is NULL (end of list) and is never allocated. Store/remove FSMs use
//  the RAM port to read/write nodes and request fresh node addresses here.
// PARAMETERS
//  ADDR_W    10  RAM address width; depth is 2**ADDR_W
//  DATA_W    32  RAM word width
//  USED_BIT  31  word bit that marks a slot occupied
// PORTS
//  clock          in   1       single clock, all logic on posedge
//  resetn         in   1       asynchronous, active-low reset
//  address        in   ADDR_W  RAM read/write address
//  data           in   DATA_W  RAM write data
//  wren           in   1       RAM write enable
//  q              out  DATA_W  RAM read data, registered
//  alloc_enable   in   1       request one free slot; sampled only when idle
//  alloc_busy     out  1       scan in progress
//  adr_found      out  1       one-cycle pulse: alloc_address is valid
//  alloc_address  out  ADDR_W  allocated slot; held until next grant
//  alloc_full     out  1       one-cycle pulse: no free slot exists
// BEHAVIOUR
//  Reset:
//   - q, alloc_address and all flags go to 0; used-bitmap cleared (all free).
//   - Scan pointer goes to 1; FSM goes to IDLE.
//   - RAM array contents are not reset.
//  RAM:
//   - On a posedge with wren=1: mem[address] <= data.
//   - Read latency is 1 cycle: q <= mem[address] at each posedge.
//   - Read-during-write to the same address returns the OLD word.
//  Bitmap:
//   - 1024-bit used[] register. Every RAM write sets used[address] <= data[USED_BIT].
//   - A write with bit31=0 therefore frees the slot.
//   - used[0] is treated as permanently set.
//  FSM IDLE -> SCAN -> IDLE:
//   - IDLE: alloc_enable=1 at a posedge enters SCAN with alloc_busy=1.
//   - SCAN: examines used[ptr] combinationally, one entry per cycle.
//   - Slot counts as taken if used[ptr]=1, or if this cycle has wren=1,
//     address==ptr and data[31]=1.
//   - Free slot at the posedge: alloc_address <= ptr, adr_found <= 1 for one cycle,
//     used[ptr] <= 1 (reserved, so it is never granted twice), ptr <= ptr+1,
//     return to IDLE.
//   - Taken slot: ptr <= ptr+1.
//   - Pointer wraps 1023 -> 1 and never visits 0.
//   - After 1023 consecutive taken entries: alloc_full pulses for 1 cycle, FSM
//     returns to IDLE, adr_found stays 0.
//   - Latency: request sampled at edge k gives adr_found high after edge k+2+n,
//     where n is the number of entries skipped.
//  Boundary conditions:
//   - alloc_enable while busy is ignored; no queueing.
//   - Held high in IDLE, alloc_enable starts a new scan each time the FSM returns
//     to IDLE.
//   - Same-edge write clearing used[ptr] while ptr is examined: the scan uses the
//     pre-edge bit (taken); the write still takes effect.
//   - Same-edge write to alloc_address right after grant: the write's bit31
//     overrides the reservation.
//   - resetn low mid-scan: abort immediately with no grant.
// STRUCTURE
//  Package card_mem_pkg holds:
//   - ADDR_W, DATA_W, DEPTH=1024, NULL_ADDR=0.
//   - USED_BIT=31, SUIT_MSB/LSB=21/20, VALUE_MSB/LSB=19/16, NEXT_MSB/LSB=9/0.
//   - Function pack_card(suit, value, next).
//   - FSM state enum {IDLE, SCAN}.
//  One sub-module: ram1024x32 (address, clock, data, wren, q), pure storage with
//  no reset.
//  Allocator FSM, bitmap and pointer live in card_mem_allocator.
// TESTING
//  - After reset, pulse alloc_enable -> adr_found after 2 cycles with alloc_address=1;
//    a second request returns 2.
//  - Write 0x8000_0003 to addr 3, then request twice -> grants 4 and 5 (3 is skipped).
//  - Write 0x0000_0000 to addr 1 (free), run allocations until the pointer wraps
//    -> addr 1 is granted again; addr 0 is never granted.
//  - Mark all 1..1023 used, then request -> alloc_full pulses after 1024 cycles
//    with adr_found=0; free 700 and request -> grant 700.
//  - RAM: write 0x8023_0005 @ addr 10, read @ 10 -> q=0x8023_0005 one cycle later;
//    read-during-write returns the old word.
//  - Assert resetn low mid-scan -> busy/found/full all 0, next request grants 1.

Source files
------------

// File: rtl/card_mem_pkg.sv
// Shared constants, node word layout and allocator state type for card storage.
// Each RAM word is one list node: used flag, suit, value and next-node address.
package card_mem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

    localparam int USED_BIT  = 31;
    localparam int SUIT_MSB  = 21;
    localparam int SUIT_LSB  = 20;
    localparam int VALUE_MSB = 19;
    localparam int VALUE_LSB = 16;
    localparam int NEXT_MSB  = 9;
    localparam int NEXT_LSB  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } alloc_state_t;

    // Builds an occupied node word; every bit outside the fields stays zero.
    function automatic logic [DATA_W-1:0] pack_card(
        input logic [1:0]        suit,
        input logic [3:0]        value,
        input logic [ADDR_W-1:0] next
    );
        logic [DATA_W-1:0] w;
        w                      = '0;
        w[USED_BIT]            = 1'b1;
        w[SUIT_MSB:SUIT_LSB]   = suit;
        w[VALUE_MSB:VALUE_LSB] = value;
        w[NEXT_MSB:NEXT_LSB]   = next;
        return w;
    endfunction

endpackage

// File: rtl/ram1024x32.sv
// Single-port synchronous RAM, one-cycle registered read, old data on
// read-during-write. Pure storage: nothing here is reset.
module ram1024x32 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (wren)
            mem[address] <= data;
        q <= mem[address];
    end

endmodule

// File: rtl/card_mem_allocator.sv
// Card node storage plus a free-slot allocator that scans a used-bitmap one
// entry per cycle and hands out node addresses, never the NULL address 0.
import card_mem_pkg::*;

module card_mem_allocator #(
    parameter int ADDR_W   = card_mem_pkg::ADDR_W,
    parameter int DATA_W   = card_mem_pkg::DATA_W,
    parameter int USED_BIT = card_mem_pkg::USED_BIT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    input  logic              alloc_enable,
    output logic              alloc_busy,
    output logic              adr_found,
    output logic [ADDR_W-1:0] alloc_address,
    output logic              alloc_full
);

    localparam int DEPTH_L = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] NULL_A   = '0;
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH_L - 1);
    localparam logic [ADDR_W-1:0] SCAN_MAX = ADDR_W'(DEPTH_L - 2);

    alloc_state_t       state;
    logic [DEPTH_L-1:0] used;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  ptr_nxt;
    logic [ADDR_W-1:0]  scan_cnt;
    logic               write_hit;
    logic               slot_taken;
    logic               grant;

    // Scan decision, registered once more before reaching the outputs.
    logic               pend_found;
    logic               pend_full;
    logic [ADDR_W-1:0]  pend_addr;

    logic [DATA_W-1:0]  q_raw;
    logic               q_vld;

    ram1024x32 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .address (address),
        .clock   (clock),
        .data    (data),
        .wren    (wren),
        .q       (q_raw)
    );

    // The RAM output register has no reset; mask it until the first edge after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            q_vld <= 1'b0;
        else
            q_vld <= 1'b1;
    end

    assign q = q_vld ? q_raw : '0;

    // An in-flight write of an occupied node counts as taken in the same cycle.
    assign write_hit  = wren && (address == ptr) && data[USED_BIT];
    assign slot_taken = used[ptr] | write_hit;
    assign grant      = (state == SCAN) && !slot_taken;
    assign ptr_nxt    = (ptr == LAST_A) ? FIRST_A : ptr + FIRST_A;

    // Writes are applied after the reservation so a same-edge write wins.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            used <= DEPTH_L'(1);
        end else begin
            if (grant)
                used[ptr] <= 1'b1;
            if (wren && (address != NULL_A))
                used[address] <= data[USED_BIT];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            alloc_busy    <= 1'b0;
            ptr           <= FIRST_A;
            scan_cnt      <= '0;
            pend_found    <= 1'b0;
            pend_full     <= 1'b0;
            pend_addr     <= '0;
            adr_found     <= 1'b0;
            alloc_full    <= 1'b0;
            alloc_address <= '0;
        end else begin
            adr_found  <= pend_found;
            alloc_full <= pend_full;
            if (pend_found)
                alloc_address <= pend_addr;
            pend_found <= 1'b0;
            pend_full  <= 1'b0;

            case (state)
                IDLE: begin
                    if (alloc_enable) begin
                        state      <= SCAN;
                        alloc_busy <= 1'b1;
                        scan_cnt   <= '0;
                    end
                end
                SCAN: begin
                    ptr <= ptr_nxt;
                    if (!slot_taken) begin
                        pend_found <= 1'b1;
                        pend_addr  <= ptr;
                        state      <= IDLE;
                        alloc_busy <= 1'b0;
                    end else if (scan_cnt == SCAN_MAX) begin
                        // Every non-NULL slot seen taken once: a full lap.
                        pend_full  <= 1'b1;
                        state      <= IDLE;
                        alloc_busy <= 1'b0;
                    end else begin
                        scan_cnt <= scan_cnt + FIRST_A;
                    end
                end
                default: begin
                    state      <= IDLE;
                    alloc_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_mem_allocator.sv
// Directed bench for card_mem_allocator: grants, skipping, wrap, full, RAM
// read/write behaviour and reset during a scan.
module tb_card_mem_allocator;
    import card_mem_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q;
    logic        alloc_enable = 1'b0;
    logic        alloc_busy;
    logic        adr_found;
    logic [9:0]  alloc_address;
    logic        alloc_full;

    int pass_cnt = 0;
    int total    = 0;

    card_mem_allocator dut (
        .clock         (clock),
        .resetn        (resetn),
        .address       (address),
        .data          (data),
        .wren          (wren),
        .q             (q),
        .alloc_enable  (alloc_enable),
        .alloc_busy    (alloc_busy),
        .adr_found     (adr_found),
        .alloc_address (alloc_address),
        .alloc_full    (alloc_full)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ram_write(input logic [9:0] a, input logic [31:0] d);
        address = a; data = d; wren = 1'b1;
        tick();
        wren = 1'b0; data = '0;
    endtask

    // One-cycle request, then wait (bounded) for found or full.
    task automatic request(input int bound, output logic [9:0] addr,
                           output logic found, output logic full, output int lat);
        alloc_enable = 1'b1;
        tick();
        alloc_enable = 1'b0;
        found = 1'b0; full = 1'b0; lat = 0; addr = '0;
        while (!found && !full && lat < bound) begin
            tick();
            lat++;
            found = adr_found;
            full  = alloc_full;
            addr  = alloc_address;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        total++;
        if ({alloc_busy, adr_found, alloc_full} !== 3'b000)
            $display("FAIL reset_flags got=%b want=000", {alloc_busy, adr_found, alloc_full});
        else pass_cnt++;
        total++;
        if (alloc_address !== 10'd0)
            $display("FAIL reset_addr got=%0d want=0", alloc_address);
        else pass_cnt++;
        total++;
        if (q !== 32'h0)
            $display("FAIL reset_q got=%h want=00000000", q);
        else pass_cnt++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_first_grants();
        logic [9:0] a; logic f, fl; int lat;
        request(20, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd1 && lat == 2))
            $display("FAIL first_grant got found=%b addr=%0d lat=%0d want found=1 addr=1 lat=2", f, a, lat);
        else pass_cnt++;
        request(20, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd2 && lat == 2))
            $display("FAIL second_grant got found=%b addr=%0d lat=%0d want found=1 addr=2 lat=2", f, a, lat);
        else pass_cnt++;
        tick();
        total++;
        if (!(adr_found === 1'b0 && alloc_address === 10'd2))
            $display("FAIL grant_hold got found=%b addr=%0d want found=0 addr=2", adr_found, alloc_address);
        else pass_cnt++;
    endtask

    task automatic test_skip_used();
        logic [9:0] a; logic f, fl; int lat; int extra;
        ram_write(10'd3, 32'h8000_0003);
        // Enable held into the scan cycle must be ignored, not queued.
        alloc_enable = 1'b1;
        tick();
        tick();
        alloc_enable = 1'b0;
        lat = 1; f = 1'b0; a = '0;
        while (!f && lat < 20) begin
            tick(); lat++; f = adr_found; a = alloc_address;
        end
        total++;
        if (!(f === 1'b1 && a === 10'd4 && lat == 3))
            $display("FAIL skip_grant got found=%b addr=%0d lat=%0d want found=1 addr=4 lat=3", f, a, lat);
        else pass_cnt++;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (adr_found === 1'b1 || alloc_busy === 1'b1) extra++;
        end
        total++;
        if (extra != 0)
            $display("FAIL busy_ignore got=%0d extra active cycles want=0", extra);
        else pass_cnt++;
        request(20, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd5 && lat == 2))
            $display("FAIL next_grant got found=%b addr=%0d lat=%0d want found=1 addr=5 lat=2", f, a, lat);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [9:0] a; logic f, fl; int lat; int bad; int first_bad;
        ram_write(10'd1, 32'h0000_0000);
        bad = 0; first_bad = -1;
        for (int e = 6; e <= 1023; e++) begin
            request(20, a, f, fl, lat);
            if (!(f === 1'b1 && a === 10'(e) && lat == 2)) begin
                if (bad == 0) first_bad = e;
                bad++;
            end
        end
        total++;
        if (bad != 0)
            $display("FAIL wrap_sequence got=%0d bad grants (first at %0d) want=0", bad, first_bad);
        else pass_cnt++;
        request(20, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd1 && lat == 2))
            $display("FAIL wrap_regrant got found=%b addr=%0d lat=%0d want found=1 addr=1 lat=2", f, a, lat);
        else pass_cnt++;
    endtask

    task automatic test_full();
        logic [9:0] a; logic f, fl; int lat;
        request(1100, a, f, fl, lat);
        total++;
        if (!(fl === 1'b1 && f === 1'b0 && lat == 1024))
            $display("FAIL full_pulse got full=%b found=%b lat=%0d want full=1 found=0 lat=1024", fl, f, lat);
        else pass_cnt++;
        tick();
        total++;
        if (!(alloc_full === 1'b0 && alloc_busy === 1'b0))
            $display("FAIL full_one_cycle got full=%b busy=%b want full=0 busy=0", alloc_full, alloc_busy);
        else pass_cnt++;
        ram_write(10'd700, 32'h0000_0000);
        request(1100, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd700 && lat == 700))
            $display("FAIL free_700 got found=%b addr=%0d lat=%0d want found=1 addr=700 lat=700", f, a, lat);
        else pass_cnt++;
    endtask

    task automatic test_ram();
        logic [31:0] w2;
        ram_write(10'd10, 32'h8023_0005);
        address = 10'd10;
        tick();
        total++;
        if (q !== 32'h8023_0005)
            $display("FAIL ram_read got=%h want=80230005", q);
        else pass_cnt++;
        w2 = pack_card(2'd1, 4'd1, 10'd7);
        ram_write(10'd10, w2);
        total++;
        if (q !== 32'h8023_0005)
            $display("FAIL ram_rdw_old got=%h want=80230005", q);
        else pass_cnt++;
        address = 10'd10;
        tick();
        total++;
        if (q !== 32'h8011_0007)
            $display("FAIL ram_read_new got=%h want=80110007", q);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        logic [9:0] a; logic f, fl; int lat;
        alloc_enable = 1'b1;
        tick();
        alloc_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (alloc_busy !== 1'b1)
            $display("FAIL mid_scan_busy got=%b want=1", alloc_busy);
        else pass_cnt++;
        resetn = 1'b0;
        #1;
        total++;
        if ({alloc_busy, adr_found, alloc_full} !== 3'b000)
            $display("FAIL abort_flags got=%b want=000", {alloc_busy, adr_found, alloc_full});
        else pass_cnt++;
        tick();
        resetn = 1'b1;
        tick();
        request(20, a, f, fl, lat);
        total++;
        if (!(f === 1'b1 && a === 10'd1 && lat == 2))
            $display("FAIL post_reset_grant got found=%b addr=%0d lat=%0d want found=1 addr=1 lat=2", f, a, lat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_grants();
        test_skip_used();
        test_wrap();
        test_full();
        test_ram();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
